// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: queues scan-code bytes in a small FIFO and
// serializes each byte as an 11-bit PS/2 frame followed by a fixed idle gap.
module ps2_device_tx #(
  parameter int HALF_BIT = 500,
  parameter int GAP      = 2000,
  parameter int ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  output logic              busy,
  output logic              ps2_clk,
  output logic              ps2_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CMAX  = (2 * HALF_BIT > GAP) ? 2 * HALF_BIT : GAP;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [CW-1:0]   HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0]   SLOT_LAST = CW'(2 * HALF_BIT - 1);
  localparam logic [CW-1:0]   GAP_LAST  = CW'(GAP - 1);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [3:0]          bit_idx, bit_idx_n;
  logic                clk_n, data_n;
  logic                pop, shift, push;
  logic [9:0]          sh;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wptr, rptr;
  logic [ADDR_W:0]     count_n;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  assign push = wr_en && !full;

  always_comb begin
    count_n = fifo_count;
    case ({push, pop})
      2'b10:   count_n = fifo_count + (ADDR_W + 1)'(1);
      2'b01:   count_n = fifo_count - (ADDR_W + 1)'(1);
      default: count_n = fifo_count;
    endcase
  end

  // FIFO control; a write while full is dropped even if a pop frees a slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      full       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + ADDR_W'(1);
      if (pop)  rptr <= rptr + ADDR_W'(1);
      fifo_count <= count_n;
      full       <= (count_n == DEPTH_CNT);
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // Shift register holds {stop, parity, data} of the frame in flight
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
    if (pop)
      sh <= {1'b1, odd_parity(mem[rptr]), mem[rptr]};
    else if (shift)
      sh <= {1'b0, sh[9:1]};
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    clk_n     = ps2_clk;
    data_n    = ps2_data;
    pop       = 1'b0;
    shift     = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n  = '0;
        clk_n  = 1'b1;
        data_n = 1'b1;
        if (fifo_count != '0) begin
          pop       = 1'b1;
          data_n    = 1'b0;
          bit_idx_n = 4'd0;
          state_n   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt == SLOT_LAST) begin
          cnt_n = '0;
          clk_n = 1'b1;
          if (bit_idx == 4'd10) begin
            data_n  = 1'b1;
            state_n = ST_GAP;
          end else begin
            bit_idx_n = bit_idx + 4'd1;
            data_n    = sh[0];
            shift     = 1'b1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
          if (cnt == HALF_LAST) clk_n = 1'b0;
        end
      end
      ST_GAP: begin
        clk_n  = 1'b1;
        data_n = 1'b1;
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Line drivers and sequencing registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= 4'd0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      ps2_clk  <= clk_n;
      ps2_data <= data_n;
      busy     <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx: a line monitor decodes frames into a queue,
// and the main sequence checks them against hand-computed bit patterns.
module tb_ps2_device_tx;

  localparam int H  = 4;
  localparam int G  = 8;
  localparam int AW = 3;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic [AW:0]   fifo_count;
  logic          overflow;
  logic          busy;
  logic          ps2_clk;
  logic          ps2_data;

  int cyc          = 0;
  int n_checks     = 0;
  int n_pass       = 0;
  int idle_toggles = 0;
  int wr_edge      = 0;

  typedef struct {
    logic [10:0] bits;
    int          nfall;
    int          t_start;
    int          t_end;
    int          bad_time;
    int          glitch;
  } frame_t;

  frame_t q[$];

  ps2_device_tx #(.HALF_BIT(H), .GAP(G), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .busy       (busy),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Line monitor: decodes frames, records fall timing relative to the start edge
  initial begin : mon
    logic   pc;
    logic   pd;
    bit     in_fr;
    frame_t f;
    pc = 1'b1;
    pd = 1'b1;
    in_fr = 1'b0;
    f = '{bits: '0, nfall: 0, t_start: 0, t_end: 0, bad_time: 0, glitch: 0};
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        in_fr = 1'b0;
      end else if (!in_fr) begin
        if (pc && !ps2_clk) idle_toggles++;
        if (pd && !ps2_data && ps2_clk) begin
          in_fr = 1'b1;
          f = '{bits: '0, nfall: 0, t_start: cyc, t_end: 0, bad_time: 0, glitch: 0};
        end
      end else begin
        if (pc && !ps2_clk) begin
          if (cyc - f.t_start != H + 2 * H * f.nfall) f.bad_time++;
          if (f.nfall < 11) f.bits[f.nfall] = ps2_data;
          f.nfall++;
        end
        if (!pc && !ps2_clk && ps2_data !== pd) f.glitch++;
        if (!pc && ps2_clk && f.nfall >= 11) begin
          f.t_end = cyc;
          q.push_back(f);
          in_fr = 1'b0;
        end
      end
      pc = ps2_clk;
      pd = ps2_data;
    end
  end

  task automatic write_byte(input logic [7:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    @(posedge clk);
    #1;
    wr_edge = cyc;
    wr_en   = 1'b0;
  endtask

  task automatic check_frame(input logic [7:0] b, input logic par, input string tag,
                             output int ts, output int te);
    frame_t      f;
    int          n;
    logic [10:0] exp_bits;
    exp_bits = {1'b1, par, b, 1'b0};
    ts = 0;
    te = 0;
    n  = 0;
    while (q.size() == 0 && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (q.size() == 0) begin
      check({tag, "_rx"}, q.size(), 1);
      return;
    end
    f  = q.pop_front();
    ts = f.t_start;
    te = f.t_end;
    check({tag, "_bits"},  f.bits, exp_bits);
    check({tag, "_nfall"}, f.nfall, 11);
    check({tag, "_timing"}, f.bad_time, 0);
    check({tag, "_glitch"}, f.glitch, 0);
    check({tag, "_len"},   f.t_end - f.t_start, 22 * H);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("idle_reached", busy, 0);
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    int         ts;
    int         te;
    int         te_first;
    int         bad;
    int         tog0;
    logic [7:0] ovb [10];
    bit         ovp [9];
    ovb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    ovp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_clk",   ps2_clk, 1);
    check("rst_data",  ps2_data, 1);
    check("rst_busy",  busy, 0);
    check("rst_full",  full, 0);
    check("rst_ovf",   overflow, 0);
    check("rst_count", fifo_count, 0);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single byte 0x1C: parity 0
    write_byte(8'h1C);
    check("single_cnt_push",  fifo_count, 1);
    check("single_busy_pre",  busy, 0);
    check("single_data_pre",  ps2_data, 1);
    @(posedge clk);
    #1;
    check("single_busy_pop",  busy, 1);
    check("single_start_bit", ps2_data, 0);
    check("single_clk_high",  ps2_clk, 1);
    check("single_cnt_pop",   fifo_count, 0);
    check_frame(8'h1C, 1'b0, "single", ts, te);
    check("single_latency", ts - wr_edge, 1);
    while (cyc < te + G - 1) begin
      @(posedge clk);
      #2;
    end
    check("single_busy_gap", busy, 1);
    @(posedge clk);
    #2;
    check("single_busy_drop", busy, 0);
    wait_idle();

    // Parity corners
    write_byte(8'h00);
    check_frame(8'h00, 1'b1, "par00", ts, te);
    wait_idle();
    write_byte(8'hFF);
    check_frame(8'hFF, 1'b1, "parFF", ts, te);
    wait_idle();
    write_byte(8'h01);
    check_frame(8'h01, 1'b0, "par01", ts, te);
    wait_idle();

    // Back-to-back make/break pair
    write_byte(8'hF0);
    check("b2b_cnt0", fifo_count, 1);
    write_byte(8'h1C);
    check("b2b_cnt1", fifo_count, 1);
    check_frame(8'hF0, 1'b1, "b2b_a", ts, te);
    te_first = te;
    check("b2b_cnt_mid", fifo_count, 1);
    check_frame(8'h1C, 1'b0, "b2b_b", ts, te);
    check("b2b_gap", ts - te_first, G + 1);
    check("b2b_cnt_end", fifo_count, 0);
    wait_idle();

    // Overflow: ten writes on consecutive edges
    wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = ovb[i];
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    check("ovf_full",  full, 1);
    check("ovf_flag",  overflow, 1);
    check("ovf_count", fifo_count, 8);
    for (int i = 0; i < 9; i++)
      check_frame(ovb[i], ovp[i], $sformatf("ovf%0d", i), ts, te);
    wait_idle();
    check("ovf_drain_count", fifo_count, 0);
    check("ovf_drain_full",  full, 0);
    check("ovf_sticky",      overflow, 1);
    check("ovf_no_extra",    q.size(), 0);

    // Reset during data bit 4 while ps2_clk is low
    write_byte(8'h55);
    ts = wr_edge;
    write_byte(8'h33);
    while (cyc < ts + 1 + 45) begin
      @(posedge clk);
      #2;
    end
    check("midrst_clk_low", ps2_clk, 0);
    #1 reset = 1'b1;
    #1;
    check("midrst_clk",   ps2_clk, 1);
    check("midrst_data",  ps2_data, 1);
    check("midrst_busy",  busy, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_ovf",   overflow, 0);
    check("midrst_full",  full, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    check("midrst_no_partial", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    write_byte(8'h2A);
    check_frame(8'h2A, 1'b0, "post_rst", ts, te);
    check("post_rst_latency", ts - wr_edge, 1);
    wait_idle();
    repeat (20) @(posedge clk);
    #2;
    check("post_rst_no_extra", q.size(), 0);

    // Long idle
    tog0 = idle_toggles;
    bad  = 0;
    repeat (10000) begin
      @(posedge clk);
      #1;
      if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_toggles", idle_toggles - tog0, 0);
    check("idle_lines",   bad, 0);
    check("idle_frames",  q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_device_tx.md
Name: ps2_device_tx

Overview:
- Device-side PS/2 transmitter: serializes scan-code bytes into ps2_clk/ps2_data frames for the apple1 core's PS/2 receiver input.
- Used in the Verilator top and in the FPGA wrapper to inject host keystrokes and pasted text.
- Contains a small byte FIFO, so a burst of scan codes, such as a make/break pair or typed text, is queued and sent back to back with a fixed inter-frame gap.

Parameters:
- HALF_BIT, 500: clk cycles per ps2_clk half-period; at 25 MHz this gives a 25 kHz PS/2 clock.
- GAP, 2000: idle clk cycles, with ps2_clk=1 and ps2_data=1, inserted after every stop bit.
- ADDR_W, 3: FIFO address width; depth = 2^ADDR_W = 8 bytes.

Ports:
- clk  in  1  system clock (25 MHz in the Apple-I design)
- reset  in  1  asynchronous reset, active-high
- wr_en  in  1  push wr_data into FIFO on this clk edge
- wr_data  in  8  scan-code byte
- full  out  1  FIFO holds 2^ADDR_W bytes
- fifo_count  out  ADDR_W+1  bytes waiting, excluding the frame in flight
- overflow  out  1  sticky: a write was dropped
- busy  out  1  FSM is not in IDLE
- ps2_clk  out  1  PS/2 clock line, idles high
- ps2_data  out  1  PS/2 data line, idles high

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - ps2_clk=1, ps2_data=1, busy=0, full=0, overflow=0, fifo_count=0.
  - FIFO pointers are cleared and the FSM goes to IDLE.
  - Any partial frame is abandoned, with no completion of remaining bits.
- All outputs are registered.
- Frame format, 11 bits: start(0), d[0]..d[7] LSB first, odd parity, stop(1).
  - Parity = ~^data, so the count of ones over data plus parity is odd.
- Bit timing: each bit slot is 2*HALF_BIT cycles.
  - ps2_data changes only at slot start, while ps2_clk=1.
  - ps2_clk stays 1 for HALF_BIT cycles, then 0 for HALF_BIT cycles.
  - The receiver samples on the ps2_clk falling edge, which comes HALF_BIT cycles after the data change.
- FSM states:
  - IDLE: if FIFO is non-empty, pop head into the shift register, register ps2_data=0 (start), bit_idx=0, go to SHIFT.
  - SHIFT: half-period counter runs 0..2*HALF_BIT-1. At the wrap, increment bit_idx. If bit_idx was 10, go to GAP with ps2_clk=1 and ps2_data=1; otherwise drive the next bit.
  - GAP: count GAP cycles with lines idle, then go to IDLE.
  - A frame lasts exactly 22*HALF_BIT cycles, measured from the start-bit data edge to the end of the stop-bit low phase.
  - The next frame's start bit comes no earlier than GAP+1 cycles after that.
- Latency: wr_en sampled at edge E into an empty FIFO with the FSM in IDLE gives:
  - pop at edge E+1, so ps2_data=0 and busy=1 are visible after E+1;
  - first ps2_clk fall at edge E+1+HALF_BIT.
- FIFO:
  - Synchronous write.
  - A write while full is dropped and sets overflow, which stays set until reset. This holds even if a pop occurs in the same cycle.
  - A simultaneous push and pop when not full leaves fifo_count unchanged.
  - Pointers wrap modulo 2^ADDR_W.
  - fifo_count ranges 0..2^ADDR_W.
- The byte in flight is held in the shift register, so FIFO contents never change the current frame.
- Counters are sized to hold max(2*HALF_BIT, GAP) without overflow.

Test Plan:
- Single byte: write 0x1C at edge 0, HALF_BIT=4, GAP=8.
  - ps2_data=0 after edge 1; bits sampled at the 11 ps2_clk falls are 0,0,0,1,1,1,0,0,0,0,1 (parity 0).
  - Falls occur at edges 5,13,...,85.
  - busy drops after GAP.
- Parity corners: 0x00 gives parity bit 1; 0xFF gives parity bit 1; 0x01 gives parity bit 0.
  - The stop bit is always 1, and each frame is exactly 88 cycles with HALF_BIT=4.
- Back-to-back: write 0xF0 then 0x1C on consecutive cycles.
  - Two frames are sent in order.
  - Between them, ps2_clk=1 and ps2_data=1 for exactly GAP+1 cycles.
  - fifo_count sequence is 1,1,0.
- Overflow: 10 writes on consecutive cycles, with ADDR_W=3.
  - Bytes 0..8 are accepted; byte 9 is dropped.
  - After edge 9: full=1, overflow=1, fifo_count=8.
  - Nine frames are transmitted in order.
- Reset mid-frame: assert reset during data bit 4, with ps2_clk low.
  - ps2_clk and ps2_data go to 1 without waiting for clk; FIFO is empty and overflow=0.
  - After release, a new write of 0x2A produces a clean full frame.
- Idle: no writes for 10000 cycles leaves ps2_clk=1, ps2_data=1, busy=0, with no ps2_clk toggles.
